// File: rtl/bnn_chip_driver.sv
// Host-side sequencer for the 1-bit BNN column chip:
// weight fill/load burst, chip clear, activation stream, drain and pop-out.
module bnn_chip_driver #(
    parameter int O_CH           = 64,
    parameter int OUT_ROW_LENGTH = 4,
    parameter int ACT_BEATS      = 16,
    parameter int DRAIN_CYCLES   = 66
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic                      reuse_w_in,
    input  logic                      w_valid_in,
    output logic                      w_ready_out,
    input  logic [8:0]                w_data_in,
    input  logic                      a_valid_in,
    output logic                      a_ready_out,
    input  logic [8:0]                a_data_in,
    output logic [8:0]                data_out,
    output logic                      load_weight_out,
    output logic                      in_valid_out,
    output logic                      pop_out,
    output logic                      chip_rst_n_out,
    input  logic [OUT_ROW_LENGTH-1:0] sum_in,
    output logic                      res_valid_out,
    output logic [OUT_ROW_LENGTH-1:0] res_data_out,
    output logic [$clog2(O_CH)-1:0]   res_ch_out,
    output logic                      busy_out,
    output logic                      done_out
);

    localparam int CHW = $clog2(O_CH);
    localparam int CW  = $clog2(O_CH + ACT_BEATS + DRAIN_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_POP,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [8:0]    buffer [O_CH];
    logic          w_fire;
    logic          a_fire;

    assign cnt_nxt = cnt + CW'(1);
    assign w_fire  = w_valid_in && w_ready_out;
    assign a_fire  = a_valid_in && a_ready_out;

    // Weight buffer is deliberately not reset so reuse survives a reset.
    always_ff @(posedge clk_in) begin
        if (w_fire) begin
            buffer[cnt[CHW-1:0]] <= w_data_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= S_IDLE;
            cnt             <= '0;
            w_ready_out     <= 1'b0;
            a_ready_out     <= 1'b0;
            data_out        <= '0;
            load_weight_out <= 1'b0;
            in_valid_out    <= 1'b0;
            pop_out         <= 1'b0;
            chip_rst_n_out  <= 1'b0;
            res_valid_out   <= 1'b0;
            res_data_out    <= '0;
            res_ch_out      <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
        end else begin
            data_out        <= '0;
            load_weight_out <= 1'b0;
            in_valid_out    <= 1'b0;
            pop_out         <= 1'b0;
            res_valid_out   <= 1'b0;
            done_out        <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    chip_rst_n_out <= 1'b1;
                    if (start_in) begin
                        busy_out <= 1'b1;
                        if (reuse_w_in) begin
                            state          <= S_CLEAR;
                            chip_rst_n_out <= 1'b0;
                        end else begin
                            state       <= S_FILL;
                            w_ready_out <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (w_fire) begin
                        if (cnt == CW'(O_CH - 1)) begin
                            state           <= S_LOAD;
                            w_ready_out     <= 1'b0;
                            cnt             <= '0;
                            load_weight_out <= 1'b1;
                            // Single-channel case: word 0 is the one being written now.
                            data_out        <= (O_CH == 1) ? w_data_in : buffer[0];
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end
                S_LOAD: begin
                    if (cnt == CW'(O_CH - 1)) begin
                        state          <= S_CLEAR;
                        chip_rst_n_out <= 1'b0;
                        cnt            <= '0;
                    end else begin
                        load_weight_out <= 1'b1;
                        data_out        <= buffer[cnt_nxt[CHW-1:0]];
                        cnt             <= cnt_nxt;
                    end
                end
                S_CLEAR: begin
                    state          <= S_STREAM;
                    chip_rst_n_out <= 1'b1;
                    a_ready_out    <= 1'b1;
                end
                S_STREAM: begin
                    if (a_fire) begin
                        data_out     <= a_data_in;
                        in_valid_out <= 1'b1;
                        if (cnt == CW'(ACT_BEATS - 1)) begin
                            state       <= S_DRAIN;
                            a_ready_out <= 1'b0;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end
                S_DRAIN: begin
                    // First DRAIN cycle still shows the final beat.
                    if (cnt == CW'(DRAIN_CYCLES)) begin
                        state   <= S_POP;
                        pop_out <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_POP: begin
                    res_valid_out <= 1'b1;
                    res_data_out  <= sum_in;
                    res_ch_out    <= cnt[CHW-1:0];
                    if (cnt == CW'(O_CH - 1)) begin
                        state    <= S_DONE;
                        done_out <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        pop_out <= 1'b1;
                        cnt     <= cnt_nxt;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy_out <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
